// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, FSM state encoding and shift-kind helpers for the
// RV32 execute unit. The control codes match those produced by ALUDecoder.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_BLT  = 4'b1011;
  localparam logic [3:0] ALU_BLTU = 4'b1101;
  localparam logic [3:0] ALU_BNE  = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic shift_kind_t shift_kind(input logic [3:0] code);
    case (code)
      ALU_SRL: return SH_SRL;
      ALU_SRA: return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational shifter covering one iteration: shifts value by amount
// (at most SHIFT_STEP) as a logical-left, logical-right or arithmetic-right.
module alu_shift_step
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  localparam int AMT_W     = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0]  value,
  input  logic [AMT_W-1:0] amount,
  input  shift_kind_t      kind,
  output logic [XLEN-1:0]  shifted
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    shifted = value;
    case (kind)
      SH_SLL:  shifted = value << amount;
      SH_SRL:  shifted = value >> amount;
      SH_SRA:  shifted = $signed(value) >>> amount;
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle RV32 integer execute unit with valid/ready handshakes on both sides.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; otherwise shifts iterate.
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            flag
);

  localparam int SHAMT_W = $clog2(XLEN);
`ifdef ALU_BARREL_SHIFT_EN
  localparam int EFF_STEP = XLEN;
`else
  localparam int EFF_STEP = SHIFT_STEP;
`endif
  localparam int AMT_W = $clog2(EFF_STEP + 1);

  state_t            state;
  logic [SHAMT_W-1:0] shamt;

  logic [XLEN-1:0]  alu_res;
  logic             alu_flag;
  logic             lt_s;
  logic             lt_u;
  logic             cmp_sel;
  logic             cmp_flag;

  logic [XLEN-1:0]  sh_value;
  logic [AMT_W-1:0] sh_amount;
  shift_kind_t      sh_kind;
  logic [XLEN-1:0]  sh_out;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign shamt     = op_b[SHAMT_W-1:0];

  // Single-cycle ops; unused codes fall through to ADD.
  always_comb begin
    lt_s     = $signed(op_a) < $signed(op_b);
    lt_u     = op_a < op_b;
    alu_res  = op_a + op_b;
    cmp_sel  = 1'b0;
    cmp_flag = 1'b0;
    case (alu_ctrl)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SUB: begin
        alu_res  = op_a - op_b;
        cmp_sel  = 1'b1;
        cmp_flag = (op_a == op_b);
      end
      ALU_SLT: begin
        alu_res  = XLEN'(lt_s);
        cmp_sel  = 1'b1;
        cmp_flag = !lt_s;
      end
      ALU_SLTU: begin
        alu_res  = XLEN'(lt_u);
        cmp_sel  = 1'b1;
        cmp_flag = !lt_u;
      end
      ALU_BLT: begin
        alu_res  = XLEN'(lt_s);
        cmp_sel  = 1'b1;
        cmp_flag = lt_s;
      end
      ALU_BLTU: begin
        alu_res  = XLEN'(lt_u);
        cmp_sel  = 1'b1;
        cmp_flag = lt_u;
      end
      ALU_BNE: begin
        alu_res  = XLEN'(op_a != op_b);
        cmp_sel  = 1'b1;
        cmp_flag = (op_a != op_b);
      end
      default: alu_res = op_a + op_b;
    endcase
    alu_flag = cmp_sel ? cmp_flag : ~|alu_res;
  end

`ifdef ALU_BARREL_SHIFT_EN
  // The shifter sees the live request and covers the whole shamt in one pass.
  assign sh_value  = op_a;
  assign sh_amount = AMT_W'(shamt);
  assign sh_kind   = shift_kind(alu_ctrl);
`else
  localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W + 1)'(SHIFT_STEP);

  logic [XLEN-1:0]    shift_val;
  shift_kind_t        kind_q;
  logic [SHAMT_W-1:0] remaining;
  logic [SHAMT_W:0]   rem_ext;
  logic [AMT_W-1:0]   step_amt;
  logic [SHAMT_W-1:0] rem_next;

  // Each iteration shifts by min(SHIFT_STEP, remaining).
  always_comb begin
    rem_ext = {1'b0, remaining};
    if (rem_ext < STEP_EXT) step_amt = rem_ext[AMT_W-1:0];
    else                    step_amt = STEP_EXT[AMT_W-1:0];
    rem_next = remaining - SHAMT_W'(step_amt);
  end

  assign sh_value  = shift_val;
  assign sh_amount = step_amt;
  assign sh_kind   = kind_q;
`endif

  alu_shift_step #(
    .XLEN       (XLEN),
    .SHIFT_STEP (EFF_STEP)
  ) u_shift_step (
    .value   (sh_value),
    .amount  (sh_amount),
    .kind    (sh_kind),
    .shifted (sh_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      flag   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      shift_val <= '0;
      kind_q    <= SH_SLL;
      remaining <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift(alu_ctrl)) begin
`ifdef ALU_BARREL_SHIFT_EN
              result <= sh_out;
              flag   <= ~|sh_out;
              state  <= DONE;
`else
              if (shamt == '0) begin
                result <= op_a;
                flag   <= ~|op_a;
                state  <= DONE;
              end else begin
                shift_val <= op_a;
                kind_q    <= shift_kind(alu_ctrl);
                remaining <= shamt;
                state     <= SHIFT;
              end
`endif
            end else begin
              result <= alu_res;
              flag   <= alu_flag;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
          state <= IDLE;
`else
          shift_val <= sh_out;
          remaining <= rem_next;
          if (rem_next == '0) begin
            result <= sh_out;
            flag   <= ~|sh_out;
            state  <= DONE;
          end
`endif
        end
        DONE: begin
          // Returning to IDLE here means no request is accepted this cycle.
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle RV32 integer execute unit that consumes the 4-bit ALU control code produced by ALUDecoder, plus two operands.
- Returns a registered result and a branch/compare flag over valid/ready handshakes.
- Logic/arith/compare ops complete in one cycle; shifts iterate SHIFT_STEP bits per cycle.
- Sits between the register-read stage and writeback/branch-resolve in the multi-cycle core.

Parameters:
- XLEN, 32, operand/result width.
- SHIFT_STEP, 1, bits shifted per iteration; power of two, 1..XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request
- alu_ctrl  in  4  control code from ALUDecoder
- op_a  in  XLEN  operand A (rs1)
- op_b  in  XLEN  operand B (rs2/imm); shamt = op_b[4:0]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- flag  out  1  compare/branch-taken flag

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, out_valid=0, result=0, flag=0, shift counter=0. in_ready=1 after release. Reset asserted mid-shift or in DONE aborts the operation; the result is discarded.
- States: IDLE, SHIFT, DONE. in_ready=(state==IDLE). out_valid=(state==DONE).
- IDLE: accept on in_valid&&in_ready; latch operands and code.
  - Non-shift code, or shift with shamt=0: compute, register, go to DONE. Latency 1 cycle, so out_valid is high on the next edge.
  - Shift with shamt>0: go to SHIFT.
- SHIFT: each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining. Go to DONE when remaining reaches 0. Total latency = 1+ceil(shamt/SHIFT_STEP).
- DONE: result/flag held stable while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE. No new request is accepted in the same cycle; throughput is at most 1 op per 2 cycles.
- in_valid while busy is ignored; the requester must hold it.
- Codes, with result and flag:
  - 0000 AND: result a&b; flag = result==0.
  - 0001 OR: result a|b; flag = result==0.
  - 0010 ADD: result a+b mod 2^XLEN; flag = result==0.
  - 0110 SUB: result a-b; flag = (a==b) (BEQ taken).
  - 1010 XOR: result a^b; flag = result==0.
  - 1000 SLL, 1001 SRL: logical shift; flag = result==0.
  - 0011 SRA: arithmetic shift, sign-filled; flag = result==0.
  - 0111 SLT/BGE: result = {0, a<s b}; flag = !(a<s b).
  - 1111 SLTU/BGEU: result = {0, a<u b}; flag = !(a<u b).
  - 1011 BLT: result = {0, a<s b}; flag = a<s b.
  - 1101 BLTU: result = {0, a<u b}; flag = a<u b.
  - 1110 BNE: result = {0, a!=b}; flag = a!=b.
  - Unused codes 0100, 0101, 1100: execute as ADD.
- Overflow is ignored; no exceptions. Shift amount uses only op_b[4:0] (XLEN=32).

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts complete in a single cycle via a combinational barrel shifter; SHIFT state unreachable; every op has latency 1.
- Undefined: iterative shifting as described above.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package alu_ctrl_pkg holds:
  - localparams for all 4-bit control codes, shared with ALUDecoder;
  - state encoding constants IDLE/SHIFT/DONE.
- Sub-module alu_shift_step: combinational one-iteration shifter.
  - Inputs: value, amount (≤SHIFT_STEP), kind (SLL/SRL/SRA).
  - Output: shifted value.
  - Instantiated once in the SHIFT datapath.

Test Plan:
- ADD a=5, b=7 -> out_valid one cycle after accept, result=12, flag=0.
- SUB a=b=0x0000_0009 -> result=0, flag=1; BNE (1110) same operands -> result=0, flag=0.
- SRA a=0x8000_0000, b=4, SHIFT_STEP=1 -> result=0xF800_0000 after 5 cycles; with ALU_BARREL_SHIFT_EN, after 1 cycle. SLL with b=0 -> latency 1, result=a.
- SLTU a=1, b=0xFFFF_FFFF -> result=1, flag=0; SLT same operands -> result=0, flag=1.
- Hold out_ready=0 for 3 cycles after out_valid -> result/flag/out_valid stable, in_ready=0, extra in_valid ignored; on out_ready=1 -> IDLE next cycle.
- Assert rst_n=0 during an SRL with shamt=31 -> out_valid, result, flag go to 0 immediately; in_ready=1 after release; no stale result is emitted.
